display_multiplex: RTL

DISPLAY_MULTIPLEX -- requirements
Module: display_multiplex

---
 rtl/display_multiplex_pkg.sv | 25 ++
 rtl/display_multiplex_glyph_rom.sv | 15 +
 rtl/display_multiplex.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/display_multiplex_pkg.sv
// Shared glyph constants and segment table
// for the multiplexed 7-segment display.
package display_multiplex_pkg;

  localparam logic [3:0] GLYPH_E     = 4'hA;
  localparam logic [3:0] GLYPH_N     = 4'hB;
  localparam logic [3:0] GLYPH_P     = 4'hC;
  localparam logic [3:0] GLYPH_DASH  = 4'hD;
  localparam logic [3:0] GLYPH_BLANK = 4'hE;
  localparam logic [3:0] GLYPH_DOT   = 4'hF;

  // Active-high segments, bit7..bit0 = a,b,c,d,e,f,g,dp
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
    8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
    8'b11111110, 8'b11110110, 8'b10011110, 8'b00101010,
    8'b11001110, 8'b00000010, 8'b00000000, 8'b00000001
  };

  // Counter width for a modulus, never narrower than one bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/display_multiplex_glyph_rom.sv
// Combinational glyph decoder:
// 4-bit code to active-high segment pattern.
module seg_glyph_rom
  import display_multiplex_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  // Table lookup of the selected glyph
  always_comb begin
    seg = SEG_TABLE[code];
  end

endmodule

// File: rtl/display_multiplex.sv
// Time-multiplexed 7-segment driver with
// double-buffered codes and per-digit blink.
module display_multiplex
  import display_multiplex_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 32,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] codes_in,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  load,
  output logic                  pending,
  output logic [7:0]            segments,
  output logic [N_DIGITS-1:0]   digit_en
);

  localparam int SLOT_W = clog2_min1(REFRESH_DIV);
  localparam int IDX_W  = clog2_min1(N_DIGITS);
  localparam int FRM_W  = clog2_min1(BLINK_FRAMES);

  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_DEAD =
    SLOT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST =
    FRM_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic              phase_q, phase_d;
  logic              pending_q, pending_d;

  logic [N_DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0][3:0] active_q, active_d;
  logic [N_DIGITS-1:0]      sblink_q, sblink_d;
  logic [N_DIGITS-1:0]      ablink_q, ablink_d;

  logic                slot_wrap;
  logic                frame_start;
  logic [3:0]          sel_code;
  logic [7:0]          glyph;
  logic [7:0]          seg_d, seg_q;
  logic [N_DIGITS-1:0] en_d, en_q;

  // Next state of counters, blink phase and buffers
  always_comb begin
    slot_wrap   = (slot_q == SLOT_LAST);
    frame_start = slot_wrap && (idx_q == IDX_LAST);

    slot_d = slot_wrap ? '0 : slot_q + 1'b1;

    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Transfer sees the pre-load shadow on a shared edge
    active_d = active_q;
    ablink_d = ablink_q;
    if (frame_start && pending_q) begin
      active_d = shadow_q;
      ablink_d = sblink_q;
    end

    shadow_d = shadow_q;
    sblink_d = sblink_q;
    if (load) begin
      shadow_d = codes_in;
      sblink_d = blink_mask;
    end

    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (frame_start) begin
      pending_d = 1'b0;
    end
  end

  // Glyph code of the digit shown next cycle
  always_comb begin
    sel_code = active_d[idx_d];
  end

  seg_glyph_rom u_rom (
    .code (sel_code),
    .seg  (glyph)
  );

  // Output pattern from next state, so outputs
  // line up with the counters they describe
  always_comb begin
    en_d  = '0;
    seg_d = '0;
    if (slot_d >= SLOT_DEAD) begin
      en_d  = N_DIGITS'(1) << idx_d;
      seg_d = (phase_d && ablink_d[idx_d]) ? '0 : glyph;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      phase_q   <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= {N_DIGITS{GLYPH_BLANK}};
      active_q  <= {N_DIGITS{GLYPH_BLANK}};
      sblink_q  <= '0;
      ablink_q  <= '0;
      seg_q     <= '0;
      en_q      <= '0;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      sblink_q  <= sblink_d;
      ablink_q  <= ablink_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
    end
  end

  assign pending  = pending_q;
  assign segments = seg_q ^ {8{ACTIVE_LOW}};
  assign digit_en = en_q ^ {N_DIGITS{ACTIVE_LOW}};

endmodule
